// File: rtl/seg7_pkg.sv
// Segment pattern constants for active-low 7-segment buses (bit0=a .. bit6=g).
// Pure definitions: no latency or flow control involved.
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps an active-low segment pattern back to its hex nibble, flagging blank and unknown patterns.
// Purely combinational (0 cycles); no flow control.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic [3:0]       nibble_o,
  output logic             blank_o,
  output logic             invalid_o
);

  always_comb begin
    nibble_o  = 4'h0;
    blank_o   = 1'b0;
    invalid_o = 1'b0;
    case (seg_i)
      SEG_0:     nibble_o = 4'h0;
      SEG_1:     nibble_o = 4'h1;
      SEG_2:     nibble_o = 4'h2;
      SEG_3:     nibble_o = 4'h3;
      SEG_4:     nibble_o = 4'h4;
      SEG_5:     nibble_o = 4'h5;
      SEG_6:     nibble_o = 4'h6;
      SEG_7:     nibble_o = 4'h7;
      SEG_8:     nibble_o = 4'h8;
      SEG_9:     nibble_o = 4'h9;
      SEG_A:     nibble_o = 4'hA;
      SEG_B:     nibble_o = 4'hB;
      SEG_C:     nibble_o = 4'hC;
      SEG_D:     nibble_o = 4'hD;
      SEG_E:     nibble_o = 4'hE;
      SEG_F:     nibble_o = 4'hF;
      SEG_BLANK: blank_o  = 1'b1;
      default:   invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Rebuilds the value shown on a scanned 7-seg display; SEG_DP_EN adds decimal-point capture.
// Latency: 2-flop sync + STABLE_CYCLES settle, frame_valid 1 cycle after last digit; no backpressure.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
`ifdef SEG_DP_EN
  input  logic                    dp_in,
`endif
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
`ifdef SEG_DP_EN
  output logic [NUM_DIGITS-1:0]   dp_out,
`endif
  output logic                    frame_valid,
  output logic                    err_pattern,
  output logic                    scan_timeout
);

  localparam int STB_W = $clog2(STABLE_CYCLES);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
`ifdef SEG_DP_EN
  localparam int SMP_W = NUM_DIGITS + SEG_W + 1;
`else
  localparam int SMP_W = NUM_DIGITS + SEG_W;
`endif

  logic [SMP_W-1:0]        smp_raw, smp_s1_q, smp_s2_q, smp_prev_q;
  logic [STB_W-1:0]        stab_q, stab_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] shad_nib_q, shad_nib_d;
  logic [NUM_DIGITS-1:0]   shad_blank_q, shad_blank_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic                    fv_q, fv_d;
  logic                    err_q, err_d;
  logic                    tmo_flag_q, tmo_flag_d;
  logic                    tmo_hit;

  logic [SEG_W-1:0]        seg_s;
  logic [NUM_DIGITS-1:0]   an_low;
  logic                    same, capture, frame_done;
  logic [3:0]              dec_nib;
  logic                    dec_blank, dec_invalid;

`ifdef SEG_DP_EN
  logic [NUM_DIGITS-1:0]   shad_dp_q, shad_dp_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  assign smp_raw = {dp_in, an_in, seg_in};
`else
  assign smp_raw = {an_in, seg_in};
`endif

  assign seg_s  = smp_s2_q[SEG_W-1:0];
  assign an_low = ~smp_s2_q[SEG_W +: NUM_DIGITS];

  seg7_pattern_decode u_decode (
    .seg_i     (seg_s),
    .nibble_o  (dec_nib),
    .blank_o   (dec_blank),
    .invalid_o (dec_invalid)
  );

  // Capture fires on the single cycle the settle counter steps onto its saturation value.
  assign same       = (smp_s2_q == smp_prev_q);
  assign capture    = same && (stab_q == STB_W'(STABLE_CYCLES - 2)) && ($countones(an_low) == 1);
  assign frame_done = &mask_q;

  always_comb begin
    stab_d       = stab_q;
    tmo_d        = tmo_q;
    tmo_hit      = 1'b0;
    mask_d       = mask_q;
    shad_nib_d   = shad_nib_q;
    shad_blank_d = shad_blank_q;
    value_d      = value_q;
    blank_d      = blank_q;
    fv_d         = 1'b0;
    tmo_flag_d   = tmo_flag_q;
`ifdef SEG_DP_EN
    shad_dp_d    = shad_dp_q;
    dp_d         = dp_q;
`endif

    if (!same) begin
      stab_d = '0;
    end else if (stab_q != STB_W'(STABLE_CYCLES - 1)) begin
      stab_d = stab_q + STB_W'(1);
    end

    if (capture) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES - 1)) begin
      tmo_d   = tmo_q + TMO_W'(1);
      tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 2));
    end

    if (frame_done) begin
      value_d = shad_nib_q;
      blank_d = shad_blank_q;
      fv_d    = 1'b1;
      mask_d  = '0;
`ifdef SEG_DP_EN
      dp_d    = shad_dp_q;
`endif
    end

    // A stalled scan drops the partial frame; value_out keeps the last complete one.
    if (tmo_hit) begin
      mask_d     = '0;
      tmo_flag_d = 1'b1;
    end

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (capture && an_low[i]) begin
        shad_nib_d[4*i +: 4] = dec_nib;
        shad_blank_d[i]      = dec_blank;
        mask_d[i]            = 1'b1;
`ifdef SEG_DP_EN
        shad_dp_d[i]         = ~smp_s2_q[SMP_W-1];
`endif
      end
    end

    if (capture) begin
      tmo_flag_d = 1'b0;
    end

    err_d = (err_q && !err_clr) || (capture && dec_invalid);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_s1_q     <= '0;
      smp_s2_q     <= '0;
      smp_prev_q   <= '0;
      stab_q       <= '0;
      tmo_q        <= '0;
      mask_q       <= '0;
      shad_nib_q   <= '0;
      shad_blank_q <= '0;
      value_q      <= '0;
      blank_q      <= '0;
      fv_q         <= 1'b0;
      err_q        <= 1'b0;
      tmo_flag_q   <= 1'b0;
`ifdef SEG_DP_EN
      shad_dp_q    <= '0;
      dp_q         <= '0;
`endif
    end else begin
      smp_s1_q     <= smp_raw;
      smp_s2_q     <= smp_s1_q;
      smp_prev_q   <= smp_s2_q;
      stab_q       <= stab_d;
      tmo_q        <= tmo_d;
      mask_q       <= mask_d;
      shad_nib_q   <= shad_nib_d;
      shad_blank_q <= shad_blank_d;
      value_q      <= value_d;
      blank_q      <= blank_d;
      fv_q         <= fv_d;
      err_q        <= err_d;
      tmo_flag_q   <= tmo_flag_d;
`ifdef SEG_DP_EN
      shad_dp_q    <= shad_dp_d;
      dp_q         <= dp_d;
`endif
    end
  end

  assign value_out    = value_q;
  assign blank_out    = blank_q;
  assign frame_valid  = fv_q;
  assign err_pattern  = err_q;
  assign scan_timeout = tmo_flag_q;
`ifdef SEG_DP_EN
  assign dp_out       = dp_q;
`endif

endmodule
